// File: rtl/dsp_be_bert_rdout_pkg.sv
// Shared widths and enums for the BERT readout stage.
// Widths mirror the backend's way count and counter width.
package dsp_be_bert_rdout_pkg;

  localparam int BERT_WAY_WIDTH      = 16;
  localparam int BER_COUNT_WIDTH     = 41;
  localparam int TOT_BER_COUNT_WIDTH = BERT_WAY_WIDTH * BER_COUNT_WIDTH;

  typedef enum logic [1:0] {
    SEL_P7   = 2'd0,
    SEL_P15  = 2'd1,
    SEL_P31  = 2'd2,
    SEL_NONE = 2'd3
  } bert_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUX   = 2'd1,
    ST_CAPT  = 2'd2,
    ST_READY = 2'd3
  } rdout_state_e;

endpackage

// File: rtl/dsp_be_bert_rdout_if.sv
// Host-side request/readback bundle of the BERT readout stage.
// master = software/host side, slave = the readout block.
interface dsp_be_bert_rdout_if
  import dsp_be_bert_rdout_pkg::*;
#(
  parameter int WAYS      = BERT_WAY_WIDTH,
  parameter int CNT_WIDTH = BER_COUNT_WIDTH
);
  localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [1:0]             cfg_sel;
  logic                   snap_req;
  logic                   rd_req;
  logic [IDX_W-1:0]       rd_way;
  logic [2:0]             shutoff_clr;

  logic                   busy;
  logic                   snap_valid;
  logic                   rd_valid;
  logic                   rd_err;
  logic [CNT_WIDTH-1:0]   rd_ber_count;
  logic [CNT_WIDTH-1:0]   rd_bit_count;
  logic                   rd_seed_good;
  logic [1:0]             snap_sel;
  logic [2:0]             shutoff_sticky;
  logic [3*CNT_WIDTH-1:0] shutoff_bitcnt;

  modport master (
    output cfg_sel, snap_req, rd_req, rd_way, shutoff_clr,
    input  busy, snap_valid, rd_valid, rd_err, rd_ber_count, rd_bit_count,
           rd_seed_good, snap_sel, shutoff_sticky, shutoff_bitcnt
  );

  modport slave (
    input  cfg_sel, snap_req, rd_req, rd_way, shutoff_clr,
    output busy, snap_valid, rd_valid, rd_err, rd_ber_count, rd_bit_count,
           rd_seed_good, snap_sel, shutoff_sticky, shutoff_bitcnt
  );

endinterface

// File: rtl/dsp_be_bert_rdout_shutoff_latch.sv
// Sticky shutoff flag for one checker, with the bit count captured on the
// first registered rising edge of the shutoff input.
module dsp_be_bert_rdout_shutoff_latch
  import dsp_be_bert_rdout_pkg::*;
#(
  parameter int CNT_WIDTH = BER_COUNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shutoff,
  input  logic [CNT_WIDTH-1:0] bit_count,
  input  logic                 clr,
  output logic                 sticky,
  output logic [CNT_WIDTH-1:0] bitcnt
);

  logic                 shutoff_q;
  logic                 shutoff_qq;
  logic [CNT_WIDTH-1:0] bit_count_q;
  logic                 rise;

  // Bit count is registered alongside the flag so the latched value matches
  // the cycle the shutoff was observed.
  assign rise = shutoff_q & ~shutoff_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      shutoff_q   <= 1'b0;
      shutoff_qq  <= 1'b0;
      bit_count_q <= '0;
      sticky      <= 1'b0;
      bitcnt      <= '0;
    end else begin
      shutoff_q   <= shutoff;
      shutoff_qq  <= shutoff_q;
      bit_count_q <= bit_count;
      if (clr) begin
        sticky <= 1'b0;
      end else if (rise && !sticky) begin
        sticky <= 1'b1;
        bitcnt <= bit_count_q;
      end
    end
  end

endmodule

// File: rtl/dsp_be_bert_rdout.sv
// Snapshot/readout stage for the PRBS7/15/31 BERT checkers: coherent
// shadow-bank capture, indexed per-way reads and sticky shutoff tracking.
//
//   state    | meaning
//   ST_IDLE  | no snapshot held, waiting for snap_req
//   ST_MUX   | selected checker registered into the mux stage
//   ST_CAPT  | mux stage copied into the shadow bank
//   ST_READY | shadow bank valid, reads accepted
module dsp_be_bert_rdout
  import dsp_be_bert_rdout_pkg::*;
#(
  parameter int WAYS      = BERT_WAY_WIDTH,
  parameter int CNT_WIDTH = BER_COUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WAYS*CNT_WIDTH-1:0] ber_count_p7,
  input  logic [WAYS*CNT_WIDTH-1:0] ber_count_p15,
  input  logic [WAYS*CNT_WIDTH-1:0] ber_count_p31,
  input  logic [CNT_WIDTH-1:0]      bit_count_p7,
  input  logic [CNT_WIDTH-1:0]      bit_count_p15,
  input  logic [CNT_WIDTH-1:0]      bit_count_p31,
  input  logic [WAYS-1:0]           seed_good_p7,
  input  logic [WAYS-1:0]           seed_good_p15,
  input  logic [WAYS-1:0]           seed_good_p31,
  input  logic                      shutoff_p7,
  input  logic                      shutoff_p15,
  input  logic                      shutoff_p31,
  dsp_be_bert_rdout_if.slave        bus
);

  localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  rdout_state_e state;
  rdout_state_e state_nxt;

  logic [WAYS*CNT_WIDTH-1:0] sel_ber;
  logic [CNT_WIDTH-1:0]      sel_bit;
  logic [WAYS-1:0]           sel_seed;

  logic [WAYS*CNT_WIDTH-1:0] mux_ber;
  logic [CNT_WIDTH-1:0]      mux_bit;
  logic [WAYS-1:0]           mux_seed;

  logic [CNT_WIDTH-1:0]      shadow_ber [WAYS];
  logic [CNT_WIDTH-1:0]      shadow_bit;
  logic [WAYS-1:0]           shadow_seed;

  logic                      way_ok;

  logic [2:0]                sh_in;
  logic [2:0]                sh_sticky;
  logic [CNT_WIDTH-1:0]      sh_bit    [3];
  logic [CNT_WIDTH-1:0]      sh_bitcnt [3];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.busy       = 1'b0;
    bus.snap_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.snap_req) state_nxt = ST_MUX;
      end
      ST_MUX: begin
        bus.busy  = 1'b1;
        state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        bus.busy  = 1'b1;
        state_nxt = ST_READY;
      end
      ST_READY: begin
        bus.snap_valid = 1'b1;
        if (bus.snap_req) state_nxt = ST_MUX;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_ber  = '0;
    sel_bit  = '0;
    sel_seed = '0;
    case (bert_sel_e'(bus.cfg_sel))
      SEL_P7: begin
        sel_ber  = ber_count_p7;
        sel_bit  = bit_count_p7;
        sel_seed = seed_good_p7;
      end
      SEL_P15: begin
        sel_ber  = ber_count_p15;
        sel_bit  = bit_count_p15;
        sel_seed = seed_good_p15;
      end
      SEL_P31: begin
        sel_ber  = ber_count_p31;
        sel_bit  = bit_count_p31;
        sel_seed = seed_good_p31;
      end
      default: ;
    endcase
  end

  // Out-of-range indices only exist when WAYS is not a power of two.
  if (WAYS == (1 << IDX_W)) begin : g_way_full
    assign way_ok = 1'b1;
  end else begin : g_way_range
    assign way_ok = (bus.rd_way < IDX_W'(WAYS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_ber          <= '0;
      mux_bit          <= '0;
      mux_seed         <= '0;
      for (int w = 0; w < WAYS; w++) shadow_ber[w] <= '0;
      shadow_bit       <= '0;
      shadow_seed      <= '0;
      bus.snap_sel     <= '0;
      bus.rd_valid     <= 1'b0;
      bus.rd_err       <= 1'b0;
      bus.rd_ber_count <= '0;
      bus.rd_bit_count <= '0;
      bus.rd_seed_good <= 1'b0;
    end else begin
      if (state == ST_MUX) begin
        mux_ber      <= sel_ber;
        mux_bit      <= sel_bit;
        mux_seed     <= sel_seed;
        bus.snap_sel <= bus.cfg_sel;
      end
      if (state == ST_CAPT) begin
        for (int w = 0; w < WAYS; w++) begin
          shadow_ber[w] <= mux_ber[w*CNT_WIDTH +: CNT_WIDTH];
        end
        shadow_bit  <= mux_bit;
        shadow_seed <= mux_seed;
      end
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      // A read coinciding with snap_req in READY sees the old shadow, since
      // the shadow only changes in ST_CAPT.
      if (bus.rd_req) begin
        if (state == ST_READY && way_ok) begin
          bus.rd_valid     <= 1'b1;
          bus.rd_ber_count <= shadow_ber[bus.rd_way];
          bus.rd_bit_count <= shadow_bit;
          bus.rd_seed_good <= shadow_seed[bus.rd_way];
        end else begin
          bus.rd_err <= 1'b1;
        end
      end
    end
  end

  assign sh_in     = {shutoff_p31, shutoff_p15, shutoff_p7};
  assign sh_bit[0] = bit_count_p7;
  assign sh_bit[1] = bit_count_p15;
  assign sh_bit[2] = bit_count_p31;

  for (genvar k = 0; k < 3; k++) begin : g_shutoff
    dsp_be_bert_rdout_shutoff_latch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_latch (
      .clk       (clk),
      .rst       (rst),
      .shutoff   (sh_in[k]),
      .bit_count (sh_bit[k]),
      .clr       (bus.shutoff_clr[k]),
      .sticky    (sh_sticky[k]),
      .bitcnt    (sh_bitcnt[k])
    );
  end

  assign bus.shutoff_sticky = sh_sticky;

  always_comb begin
    bus.shutoff_bitcnt = '0;
    for (int k = 0; k < 3; k++) begin
      bus.shutoff_bitcnt[k*CNT_WIDTH +: CNT_WIDTH] = sh_bitcnt[k];
    end
  end

endmodule

// File: doc/dsp_be_bert_rdout.md
# dsp_be_bert_rdout

Readout stage directly downstream of the three-BERT backend (PRBS7/15/31 checkers). It selects one checker, atomically snapshots all per-way error counts, the shared bit count and the seed-good flags into a shadow bank, and serves indexed per-way reads through a req/valid handshake. It also keeps a sticky shutoff flag per checker, together with the bit count latched at shutoff, so that software reads are coherent even while the counters keep running.

## Interface
- `Ways`, 16, BERT ways per checker; the read index is `$clog2(Ways)` bits wide.
- `CntWidth`, 41, width of a per-way error count and of the bit count.
- `i_clk` input 1: the single clock, shared with the BERTs.
- `i_rst` input 1: reset. Synchronous, active-high.
- `i_ber_count_p{7,15,31}` input `Ways*CntWidth`: packed per-way error counts from each checker. Way w occupies `[w*CntWidth +: CntWidth]`.
- `i_bit_count_p{7,15,31}` input `CntWidth`: bit counts.
- `i_seed_good_p{7,15,31}` input `Ways`: seed-good flags.
- `i_shutoff_p{7,15,31}` input 1: shutoff flags.
- `i_cfg_sel` input 2: checker select. 0 = PRBS7, 1 = PRBS15, 2 = PRBS31, 3 = none (captures zeros).
- `i_snap_req` input 1: single-cycle pulse that starts a capture.
- `i_rd_req` input 1: read request for one cycle.
- `i_rd_way` input `$clog2(Ways)`: way index for the read.
- `i_shutoff_clr` input 3: clears sticky flags. Bit 0 = PRBS7, bit 1 = PRBS15, bit 2 = PRBS31.
- `o_busy` output 1: a capture is in progress.
- `o_snap_valid` output 1: the shadow bank holds a complete snapshot.
- `o_rd_valid` output 1: read data is valid, one-cycle pulse.
- `o_rd_err` output 1: the read was rejected, one-cycle pulse.
- `o_rd_ber_count` output `CntWidth`: error count for the requested way.
- `o_rd_bit_count` output `CntWidth`: snapshot bit count.
- `o_rd_seed_good` output 1: seed-good flag for the requested way.
- `o_snap_sel` output 2: value of `i_cfg_sel` used for the current snapshot.
- `o_shutoff_sticky` output 3: sticky shutoff flags.
- `o_shutoff_bitcnt` output `3*CntWidth`: bit count latched at the first rising shutoff of each checker.

## Operation
- **FSM states:** IDLE, MUX, CAPT, READY.
  - IDLE: a pulse on `i_snap_req` → MUX.
  - MUX: the selected checker's count, bit count and seed-good signals are registered into the mux stage. `o_snap_sel` is latched at the same time. → CAPT.
  - CAPT: the mux stage is copied into the shadow bank. → READY.
  - READY: `i_snap_req` → MUX (re-capture). `o_snap_valid` drops while the re-capture runs.
- `o_busy` = 1 in MUX and CAPT.
- `o_snap_valid` = 1 only in READY.
- `i_snap_req` during MUX or CAPT is ignored. It is not queued.
- **Reads:**
  - A read is accepted only in READY. It returns shadow[`i_rd_way`].
  - In any other state a read produces `o_rd_err` and leaves the data outputs unchanged.
  - A read in READY in the same cycle as `i_snap_req` is served from the old shadow, then the capture proceeds.
  - With `i_cfg_sel` = 3 the snapshot is all zeros. Reads are valid and return 0.
  - `i_rd_way` ≥ `Ways` (only reachable for a non-power-of-2 `Ways`) produces `o_rd_err`.
- **Sticky shutoff, per checker:**
  - On a 0→1 edge of the registered `i_shutoff_pN` while the sticky flag is clear: set the flag and latch that checker's bit count.
  - Further edges do not overwrite the latched value.
  - Clear has priority over set in the same cycle.
  - A clear while the shutoff input is still high does not re-set the flag. Re-setting requires a fresh rising edge.
- **Reset** (from any state, including mid-capture): FSM → IDLE. Every output, the shadow bank, the mux stage and the edge-detect registers go to 0.

## Timing
- Snapshot latency: `i_snap_req` in cycle N → `o_busy` in N+1 and N+2 → `o_snap_valid` = 1 in N+3.
- Shadow contents equal the checker values sampled at the clock edge ending cycle N+1.
- Read latency: `i_rd_req` in cycle N → `o_rd_valid` or `o_rd_err` in N+1. Data holds until the next accepted read.
- Back-to-back reads are accepted every cycle.
- Shutoff latency: input rising in cycle N → sticky flag and latched bit count in N+2 (one input register plus the edge-detect register).
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `dsp_be_pkg`:
  - `bert_sel_e` enum: `SEL_P7`, `SEL_P15`, `SEL_P31`, `SEL_NONE`.
  - `rdout_state_e` enum.
  - Widths come from the shared backend defines: `BERT_WAY_WIDTH`, `BER_COUNT_WIDTH`, `TOT_BER_COUNT_WIDTH`.
- One sub-module, `bert_shutoff_latch`, instantiated three times. It contains the input register, the edge detect, the sticky flag with clear, and the latched bit count.

## Test plan
1. **Basic snapshot and read:**
   - Stimulus: reset; set `i_cfg_sel` = 1; PRBS15 way w count = w*3+1, bit count = 1000; pulse `i_snap_req`.
   - Required: `o_snap_valid` = 1 exactly 3 cycles later.
   - Stimulus: read way 5.
   - Required: next cycle `o_rd_valid` = 1, `o_rd_ber_count` = 16, `o_rd_bit_count` = 1000.
2. **Snapshot coherence:**
   - Stimulus: increment the counts every cycle during and after capture.
   - Required: all 16 ways read back the values sampled at cycle N+1; a later re-snapshot shows the new values.
3. **Rejected reads:**
   - Stimulus: read in IDLE, and read during `o_busy`.
   - Required: `o_rd_err` = 1, `o_rd_valid` = 0, data unchanged.
   - Stimulus: `i_snap_req` during CAPT.
   - Required: no extra capture occurs.
4. **Same-cycle read and snap:**
   - Stimulus: in READY, assert a read of way 0 and `i_snap_req` together, with the shadow holding 7 and the live count 9.
   - Required: the read returns 7; a read after re-capture returns 9.
5. **Shutoff latch:**
   - Stimulus: `i_shutoff_p31` rises when the bit count is 5000, toggles later, then `i_shutoff_clr`[2] pulses while the input is still high.
   - Required: sticky flag[2] = 1 at +2 cycles with latched bit count 5000 and no overwrite on later toggles; after the clear, flag = 0 and stays 0 until a new rising edge.
6. **Reset mid-capture and sel = 3:**
   - Stimulus: assert `i_rst` in CAPT.
   - Required: all outputs 0, FSM back in IDLE.
   - Stimulus: snapshot with `i_cfg_sel` = 3.
   - Required: every read returns zeros with `o_rd_valid` = 1.
